// File: rtl/mcdp_pkg.sv
// Shared definitions for the mcdp_core multicycle MIPS-subset core:
// opcode/funct encodings, FSM states, ALU operations and decode helpers.
package mcdp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic alu_op_t funct_to_op(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcdp_alu.sv
// Combinational 32-bit ALU for mcdp_core: add, sub, and, or, signed slt.
module mcdp_alu
  import mcdp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mcdp_core.sv
// Multicycle MIPS-subset core with inline 32x32 register file and a req/ack
// unified memory port. Define MCDP_BNE_EN to decode bne (opcode 0x05).
module mcdp_core
  import mcdp_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic [4:0]        dbg_addr,
  output logic [31:0]       dbg_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [31:0]       ir, a_q, b_q, alu_out, mdr;
  logic [31:0]       rf [32];

  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;

  logic [31:0]       alu_a, alu_b, alu_result;
  alu_op_t           alu_op;
  logic              alu_zero;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sext, pc_wide, jump_full;
  logic [ADDR_W-1:0] jump_tgt;
  logic              acked, take_branch;
  logic              unused_bits;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
  assign acked     = mem_req && mem_ack;

  // Upper PC bits above the 26-bit field survive only when ADDR_W exceeds 26.
  assign pc_wide   = 32'(pc);
  assign jump_full = {pc_wide[31:26], ir[25:0]};
  assign jump_tgt  = jump_full[ADDR_W-1:0];
  assign unused_bits = ^{ir[10:6], pc_wide[25:0], jump_full[31:ADDR_W]};

`ifdef MCDP_BNE_EN
  assign take_branch = (opcode == OP_BNE) ? !alu_zero : alu_zero;
`else
  assign take_branch = alu_zero;
`endif

  mcdp_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    alu_a  = a_q;
    alu_b  = imm_sext;
    alu_op = ALU_ADD;
    case (state)
      S_DECODE: alu_a = pc_wide;
      S_EXEC: begin
        if (opcode == OP_RTYPE) begin
          alu_b  = b_q;
          alu_op = funct_to_op(funct);
        end
      end
      S_BRANCH: begin
        alu_b  = b_q;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Next-state logic; memory states advance only on an acknowledged request.
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: if (acked) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_n = funct_legal(funct) ? S_EXEC : S_HALT;
          OP_ADDI:      state_n = S_EXEC;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = S_JUMP;
`ifdef MCDP_BNE_EN
          OP_BNE:       state_n = S_BRANCH;
`else
          OP_BNE:       state_n = S_HALT;
`endif
          default:      state_n = S_HALT;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (acked) state_n = S_MEMWB;
      S_MEMWR:  if (acked) state_n = S_FETCH;
      S_EXEC:   state_n = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    pc_n = pc;
    case (state)
      S_FETCH:  if (acked) pc_n = pc + ADDR_W'(1);
      S_BRANCH: if (take_branch) pc_n = alu_out[ADDR_W-1:0];
      S_JUMP:   pc_n = jump_tgt;
      default: ;
    endcase
  end

  // Outputs: retire/halted decode the current state; the bus signals are the
  // next values of registered outputs, so a request is live in the first
  // cycle of each memory state and a store's ack can start the next fetch.
  always_comb begin
    retire  = 1'b0;
    halted  = (state == S_HALT);
    req_n   = 1'b0;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = acked;
      default: ;
    endcase
    if (state_n == S_FETCH) begin
      req_n  = 1'b1;
      addr_n = pc_n;
    end else if (state_n == S_MEMRD || state_n == S_MEMWR) begin
      req_n = 1'b1;
      we_n  = (state_n == S_MEMWR);
      if (state == S_MEMADR) begin
        addr_n  = alu_result[ADDR_W-1:0];
        wdata_n = b_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pc        <= pc_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      case (state)
        S_FETCH:  if (acked) ir <= mem_rdata;
        S_DECODE: begin
          a_q     <= rf[rs];
          b_q     <= rf[rt];
          alu_out <= alu_result;
        end
        S_MEMADR, S_EXEC: alu_out <= alu_result;
        S_MEMRD:  if (acked) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = mdr;
    if (state == S_MEMWB) begin
      rf_we = 1'b1;
    end else if (state == S_ALUWB) begin
      rf_we    = 1'b1;
      rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
      rf_wdata = alu_out;
    end
  end

  // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // Entry 0 is never written, so it always reads zero.
  assign dbg_data = rf[dbg_addr];
  assign pc_out   = pc;

endmodule
